// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-and-add multiplier sequencer.
package mult_pkg;
  localparam int WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADD,
    S_SHIFT,
    S_DONE
  } mult_state_t;
endpackage

// File: rtl/step_counter.sv
// Counts SHIFT steps of one multiply; last flags the final (WIDTH-1) step.
module step_counter #(
  parameter int WIDTH = mult_pkg::WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic last
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (clear) cnt <= '0;
    else if (inc)   cnt <= cnt + 1'b1;
  end

  assign last = (cnt == CW'(WIDTH - 1));
endmodule

// File: rtl/mult_sequencer.sv
// Sequential unsigned multiplier: one ADD per set multiplier bit, one SHIFT per bit.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  mult_state_t      state, state_nxt;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic             cnt_clr, cnt_inc, cnt_last;

  step_counter #(.WIDTH(WIDTH)) u_step (
    .clk  (clk),
    .rst  (rst),
    .clear(cnt_clr),
    .inc  (cnt_inc),
    .last (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy      = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = q_reg[0] ? S_ADD : S_SHIFT;
      end
      S_ADD: begin
        busy      = 1'b1;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        busy    = 1'b1;
        cnt_inc = 1'b1;
        // q_reg[1] is the bit that lands in q_reg[0] after this shift
        if (cnt_last)      state_nxt = S_DONE;
        else if (q_reg[1]) state_nxt = S_ADD;
        else               state_nxt = S_SHIFT;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operands are captured on the accepting edge so later input changes are harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      q_reg <= '0;
      m_reg <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          m_reg <= multiplicand;
          q_reg <= multiplier;
        end
        S_LOAD:  a_reg <= '0;
        S_ADD:   a_reg <= a_reg + {1'b0, m_reg};
        S_SHIFT: {a_reg, q_reg} <= {1'b0, a_reg, q_reg[WIDTH-1:1]};
        default: ;
      endcase
    end
  end

  assign product = (state == S_DONE) ? {a_reg[WIDTH-1:0], q_reg} : '0;
endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer at WIDTH=4: vector table plus hand-written corner sequences.
module tb_mult_sequencer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_ready;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic         out_valid;
  logic         out_ready;
  logic [2*W-1:0] product;
  logic         busy;

  int n_pass = 0;
  int n_total = 0;

  mult_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_ready    (in_ready),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int exp_prod;
    int exp_lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Count edges from acceptance until out_valid, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string name, input int a, input int b, input int exp_prod,
                        input int exp_lat);
    int n;
    @(negedge clk);
    check({name, " in_ready"}, int'(in_ready), 1);
    multiplicand = W'(a);
    multiplier   = W'(b);
    start        = 1'b1;
    out_ready    = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    multiplicand = ~W'(a);
    multiplier   = ~W'(b);
    check({name, " busy"}, int'(busy), 1);
    wait_valid(n);
    check({name, " latency"}, n, exp_lat);
    check({name, " product"}, int'(product), exp_prod);
    @(posedge clk); #1;
    check({name, " valid pulse"}, int'(out_valid), 0);
    check({name, " back idle"}, int'(in_ready), 1);
  endtask

  vec_t vecs[7];
  int   n;

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    multiplicand = '0; multiplier = '0;
    #12;
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset product", int'(product), 0);
    @(negedge clk); rst = 1'b0;

    vecs[0] = '{15, 0, 0, 5};
    vecs[1] = '{15, 15, 225, 9};
    vecs[2] = '{13, 11, 143, 8};
    vecs[3] = '{1, 8, 8, 6};
    vecs[4] = '{0, 0, 0, 5};
    vecs[5] = '{3, 5, 15, 7};
    vecs[6] = '{0, 15, 0, 9};
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_prod, vecs[i].exp_lat);

    // Held result under backpressure, start ignored, then start+out_ready together.
    @(negedge clk);
    multiplicand = 4'd7; multiplier = 4'd9; start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(n);
    check("hold latency", n, 7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = i[0];
      multiplicand = W'(i);
      @(posedge clk); #1;
      if (!out_valid || product != 8'd63)
        check($sformatf("hold cyc%0d", i), int'(product), 63);
    end
    check("hold valid", int'(out_valid), 1);
    check("hold product", int'(product), 63);
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    multiplicand = 4'd2; multiplier = 4'd3;
    @(posedge clk); #1;
    check("release idle", int'(in_ready), 1);
    check("release no accept", int'(busy), 0);
    check("release product", int'(product), 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("accept after idle", int'(busy), 1);
    wait_valid(n);
    check("2x3 latency", n, 7);
    check("2x3 product", int'(product), 6);
    @(posedge clk); #1;

    // Asynchronous reset during the third SHIFT of 15*15.
    @(negedge clk);
    multiplicand = 4'd15; multiplier = 4'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort in_ready", int'(in_ready), 1);
    check("abort busy", int'(busy), 0);
    check("abort out_valid", int'(out_valid), 0);
    check("abort product", int'(product), 0);
    @(negedge clk); rst = 1'b0;
    n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("abort no pulse", n, 0);
    run_op("after reset", 3, 5, 15, 7);

    // Back-to-back requests with start held.
    @(negedge clk);
    multiplicand = 4'd6; multiplier = 4'd7; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    wait_valid(n);
    check("b2b first latency", n, 8);
    check("b2b first product", int'(product), 42);
    multiplicand = 4'd5; multiplier = 4'd10;
    @(posedge clk); #1;
    check("b2b idle", int'(in_ready), 1);
    @(posedge clk); #1;
    check("b2b second accept", int'(busy), 1);
    start = 1'b0;
    wait_valid(n);
    check("b2b second latency", n, 7);
    check("b2b second product", int'(product), 50);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply.
REQ-005 SHALL have port in_ready, output, 1 bit: high only in IDLE; a request is accepted on an edge where start and in_ready are both high.
REQ-006 SHALL have port multiplicand, input, WIDTH bits: unsigned operand a, sampled on the accepting edge.
REQ-007 SHALL have port multiplier, input, WIDTH bits: unsigned operand b, sampled on the accepting edge.
REQ-008 SHALL have port out_valid, output, 1 bit: high in DONE; product is valid while it is high.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer acceptance of the product.
REQ-010 SHALL have port product, output, 2*WIDTH bits: the unsigned result a*b.
REQ-011 SHALL have port busy, output, 1 bit: high in LOAD, ADD and SHIFT.

Function
REQ-012 SHALL implement an FSM with states IDLE, LOAD, ADD, SHIFT and DONE.
REQ-013 IDLE SHALL go to LOAD on start&in_ready and otherwise stay in IDLE.
REQ-014 LOAD SHALL set M<=multiplicand, Q<=multiplier, A (WIDTH+1 bits)<=0 and step count<=0, then go to ADD if multiplier[0]=1, else to SHIFT.
REQ-015 ADD SHALL set A<=A+M (zero-extended, carry kept in A[WIDTH]) and then go to SHIFT.
REQ-016 SHALL perform, in SHIFT: {A,Q}<={1'b0,A,Q}>>1 and step count+1.
REQ-017 After SHIFT, the next state SHALL be DONE if the count before the increment was WIDTH-1; otherwise ADD if pre-shift Q[1]=1, else SHIFT.
REQ-018 DONE SHALL drive product={A[WIDTH-1:0],Q} and hold it stable until it is accepted.
REQ-019 DONE SHALL go to IDLE on out_ready and otherwise stay in DONE.
REQ-020 Latency SHALL be exactly 1+WIDTH+popcount(multiplier) edges from the accepting edge to the first edge where out_valid=1.
REQ-021 start SHALL be ignored outside IDLE; operand changes during an operation SHALL NOT affect the result.
REQ-022 If start and out_ready are both high in DONE, the FSM SHALL return to IDLE only; the start is not accepted that cycle.
REQ-023 Zero operands SHALL NOT short-cut the sequence; the latency rule still applies.
REQ-024 product SHALL read 0 whenever the FSM is not in DONE.

Reset
REQ-025 On rst=1, regardless of the clock, the FSM SHALL enter IDLE and A, Q, M and the step count SHALL clear to 0.
REQ-026 Output reset values SHALL be: in_ready=1, out_valid=0, busy=0, product=0.
REQ-027 Reset asserted mid-operation SHALL abort it with no out_valid pulse; the first start after reset release SHALL be handled normally.

Structure
REQ-028 Package mult_pkg SHALL hold the state enum type (mult_state_t) and the default WIDTH constant.
REQ-029 The step counter SHALL be a sub-module step_counter with inputs clk, rst, clear and inc, and output last (count==WIDTH-1), using the same asynchronous reset.
REQ-030 The datapath registers A, Q and M SHALL reside in mult_sequencer; no other sub-modules.

Verification (WIDTH=4)
REQ-031 Case 1: a=15, b=0, out_ready=1 -> product=0; out_valid 5 edges after acceptance, high for 1 cycle.
REQ-032 Case 2: a=15, b=15 -> product=225; out_valid 9 edges after acceptance.
REQ-033 Case 3: a=13, b=11 -> product=143 after 8 edges; a=1, b=8 -> product=8 after 6 edges.
REQ-034 Case 4: 7*9 with out_ready=0 for 10 cycles -> out_valid and product=63 held stable; start pulses meanwhile are ignored; IDLE is entered one edge after out_ready=1.
REQ-035 Case 5: rst pulsed during the 3rd SHIFT of 15*15 -> immediate IDLE with all outputs at reset values; then 3*5 -> product=15 after 7 edges.
REQ-036 Case 6: back-to-back requests with start held high -> each product correct, and the next acceptance occurs one edge after IDLE is re-entered.
